// File: rtl/rmii_rx_frame_checker_if.sv
// Byte-stream and FIFO write-port bundle around the RMII receive frame checker.
// The master modport belongs to the checker. The slave modport is the side that feeds the stream and owns the FIFO.
interface rmii_rx_frame_checker_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_eod;
  logic       fifo_afull;
  logic [7:0] fifo_din;
  logic       fifo_wren;
  logic       fifo_EOD_in;

  modport master (
    input  in_data, in_valid, in_eod, fifo_afull,
    output fifo_din, fifo_wren, fifo_EOD_in
  );

  modport slave (
    output in_data, in_valid, in_eod, fifo_afull,
    input  fifo_din, fifo_wren, fifo_EOD_in
  );
endinterface

// File: rtl/rmii_rx_frame_checker.sv
// In-line RMII receive frame qualifier: one-cycle pass-through to the frame FIFO,
// CRC-32 and length checking, whole-frame drop on FIFO almost-full, per-frame status and counters.
module rmii_rx_frame_checker #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    REF_CLK,
  input  logic                    arst_n,
  rmii_rx_frame_checker_if.master bus,
  output logic                    stat_valid,
  output logic                    stat_fcs_ok,
  output logic [10:0]             stat_len,
  output logic                    stat_runt,
  output logic                    stat_giant,
  output logic                    stat_dropped,
  output logic [CNT_W-1:0]        cnt_good,
  output logic [CNT_W-1:0]        cnt_bad,
  output logic [CNT_W-1:0]        cnt_drop
);

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] LEN_SAT     = 11'h7FF;
  localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L       = 11'(MAX_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} state_e;

  state_e           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [10:0]      len_q, len_d;
  logic [7:0]       fifo_din_q, fifo_din_d;
  logic             fifo_wren_q, fifo_wren_d;
  logic             fifo_eod_q, fifo_eod_d;
  logic             stat_valid_q, stat_valid_d;
  logic             stat_fcs_ok_q, stat_fcs_ok_d;
  logic [10:0]      stat_len_q, stat_len_d;
  logic             stat_runt_q, stat_runt_d;
  logic             stat_giant_q, stat_giant_d;
  logic             stat_dropped_q, stat_dropped_d;
  logic [CNT_W-1:0] cnt_good_q, cnt_good_d;
  logic [CNT_W-1:0] cnt_bad_q, cnt_bad_d;
  logic [CNT_W-1:0] cnt_drop_q, cnt_drop_d;

  logic [31:0] crc_upd;
  logic [10:0] len_upd;
  logic [10:0] close_len;
  logic        close_fcs;
  logic        wr;
  logic        close_ok;
  logic        close_drop;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (((r[0] ^ b[i]) == 1'b1) ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    crc_d          = crc_q;
    len_d          = len_q;
    fifo_din_d     = fifo_din_q;
    fifo_wren_d    = 1'b0;
    fifo_eod_d     = 1'b0;
    stat_valid_d   = 1'b0;
    stat_fcs_ok_d  = stat_fcs_ok_q;
    stat_len_d     = stat_len_q;
    stat_runt_d    = stat_runt_q;
    stat_giant_d   = stat_giant_q;
    stat_dropped_d = stat_dropped_q;
    cnt_good_d     = cnt_good_q;
    cnt_bad_d      = cnt_bad_q;
    cnt_drop_d     = cnt_drop_q;
    wr             = 1'b0;
    close_ok       = 1'b0;
    close_drop     = 1'b0;
    close_len      = '0;
    close_fcs      = 1'b0;

    // In IDLE crc_q/len_q already hold their initial values, so these also seed a new frame.
    crc_upd = crc_byte(crc_q, bus.in_data);
    len_upd = (len_q == LEN_SAT) ? LEN_SAT : len_q + 11'd1;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (bus.fifo_afull) begin
            if (bus.in_eod) close_drop = 1'b1;
            else            state_d    = ST_DROP;
          end else begin
            wr    = 1'b1;
            crc_d = crc_upd;
            len_d = len_upd;
            if (bus.in_eod) close_ok = 1'b1;
            else            state_d  = ST_PASS;
          end
        end
      end
      ST_PASS: begin
        if (bus.in_valid) begin
          wr    = 1'b1;
          crc_d = crc_upd;
          len_d = len_upd;
          if (bus.in_eod) begin
            close_ok = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (bus.in_valid && bus.in_eod) begin
          close_drop = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr) begin
      fifo_din_d  = bus.in_data;
      fifo_wren_d = 1'b1;
      fifo_eod_d  = bus.in_eod;
    end

    if (close_ok || close_drop) begin
      close_len      = close_drop ? 11'd0 : len_upd;
      close_fcs      = !close_drop && (crc_upd == CRC_RESIDUE);
      stat_valid_d   = 1'b1;
      stat_fcs_ok_d  = close_fcs;
      stat_len_d     = close_len;
      stat_runt_d    = close_len < MIN_L;
      stat_giant_d   = close_len > MAX_L;
      stat_dropped_d = close_drop;
      crc_d          = CRC_INIT;
      len_d          = 11'd0;
      // Dropped outranks bad, bad outranks good: exactly one counter moves.
      if (close_drop)                                   cnt_drop_d = sat_inc(cnt_drop_q);
      else if (stat_runt_d || stat_giant_d || !close_fcs) cnt_bad_d  = sat_inc(cnt_bad_q);
      else                                              cnt_good_d = sat_inc(cnt_good_q);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      state_q        <= ST_IDLE;
      crc_q          <= CRC_INIT;
      len_q          <= '0;
      fifo_din_q     <= '0;
      fifo_wren_q    <= 1'b0;
      fifo_eod_q     <= 1'b0;
      stat_valid_q   <= 1'b0;
      stat_fcs_ok_q  <= 1'b0;
      stat_len_q     <= '0;
      stat_runt_q    <= 1'b0;
      stat_giant_q   <= 1'b0;
      stat_dropped_q <= 1'b0;
      cnt_good_q     <= '0;
      cnt_bad_q      <= '0;
      cnt_drop_q     <= '0;
    end else begin
      state_q        <= state_d;
      crc_q          <= crc_d;
      len_q          <= len_d;
      fifo_din_q     <= fifo_din_d;
      fifo_wren_q    <= fifo_wren_d;
      fifo_eod_q     <= fifo_eod_d;
      stat_valid_q   <= stat_valid_d;
      stat_fcs_ok_q  <= stat_fcs_ok_d;
      stat_len_q     <= stat_len_d;
      stat_runt_q    <= stat_runt_d;
      stat_giant_q   <= stat_giant_d;
      stat_dropped_q <= stat_dropped_d;
      cnt_good_q     <= cnt_good_d;
      cnt_bad_q      <= cnt_bad_d;
      cnt_drop_q     <= cnt_drop_d;
    end
  end

  assign bus.fifo_din    = fifo_din_q;
  assign bus.fifo_wren   = fifo_wren_q;
  assign bus.fifo_EOD_in = fifo_eod_q;
  assign stat_valid      = stat_valid_q;
  assign stat_fcs_ok     = stat_fcs_ok_q;
  assign stat_len        = stat_len_q;
  assign stat_runt       = stat_runt_q;
  assign stat_giant      = stat_giant_q;
  assign stat_dropped    = stat_dropped_q;
  assign cnt_good        = cnt_good_q;
  assign cnt_bad         = cnt_bad_q;
  assign cnt_drop        = cnt_drop_q;

endmodule
